mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline boundary register.
- Replaces the fixed 2-bit-control, 32-bit, always-advance MEM/WB latch with a two-entry skid-buffered stage carrying valid/ready handshake, flush, x0-write suppression, write-back data select and a forwarding tap for the hazard unit.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- DATA_W, 32, width of memory-read and ALU-result data.
- ADDR_W, 5, register-file address width.
- CTRL_W, 2, WB control width (>=2). Bit0 = RegWrite, bit1 = MemToReg; other bits are passed through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (synchronous).
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept (registered).
- in_ctrl  in  CTRL_W  WB control bits.
- in_mem_data  in  DATA_W  data-memory read value.
- in_alu_data  in  DATA_W  ALU result.
- in_rd_addr  in  ADDR_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back consumes head.
- out_ctrl  out  CTRL_W  head control.
- out_mem_data  out  DATA_W  head memory data.
- out_alu_data  out  DATA_W  head ALU data.
- out_rd_addr  out  ADDR_W  head destination.
- wb_data  out  DATA_W  out_ctrl[1] ? out_mem_data : out_alu_data.
- fwd_en  out  1  out_valid & out_ctrl[0].
- fwd_addr  out  ADDR_W  equals out_rd_addr.
- fwd_data  out  DATA_W  equals wb_data.

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each with a valid bit. States are EMPTY (none valid), ONE (main only) and FULL (main + skid).
- Reset (reset=1 at edge): both valids 0; all stored fields 0. Therefore out_valid=0, out_*=0, wb_data=0, fwd_en=0, in_ready=1. Reset overrides flush and any handshake, including mid-transfer.
- Signal definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~skid_valid. It is a register output with no combinational path from out_ready.
- Capture: stored ctrl[0] = in_ctrl[0] & (in_rd_addr != 0). Writes to x0 never assert RegWrite downstream. All other fields are stored unchanged.
- Transitions, no flush:
  - EMPTY: acc -> ONE; input loads into main. Latency 1 cycle from acc to out_valid.
  - ONE, acc & pop -> ONE; main reloads from input.
  - ONE, acc & ~pop -> FULL; input loads into skid.
  - ONE, ~acc & pop -> EMPTY.
  - ONE, ~acc & ~pop -> hold.
  - FULL: acc impossible (in_ready=0). pop -> ONE; skid moves to main. ~pop -> hold.
- Flush: next state EMPTY; both valids cleared; ctrl fields cleared to 0; data fields may keep their old values.
  - flush wins over a simultaneous acc; the accepted beat is dropped. Upstream must treat flush as killing it.
  - A pop in the same cycle as flush is still a legal consume of the current head.
- Order is preserved: skid data always leaves after main.
- out_* are stable while out_valid & ~out_ready.
- wb_data, fwd_* are combinational from head registers only. There is no input-to-output combinational path.
- Full throughput: with out_ready held 1, one beat per cycle and the state stays ONE.

Decomposition:
- Shared package pipe_pkg holds:
  - WB_REGWRITE_BIT=0 and WB_MEMTOREG_BIT=1.
  - Default widths DATA_W=32, ADDR_W=5.
  - The state encoding localparams EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One sub-module is natural: pipe_skid_buf, a generic 2-entry skid buffer over a packed {ctrl, mem, alu, rd} payload with flush. mem_wb_stage adds x0 suppression, the wb_data mux and the fwd_* tap around it.

Test Plan:
- Reset, then steady push:
  - Stimulus: reset=1 for 2 cycles, then in_valid=1, out_ready=1, in_ctrl=2'b01, rd=5, alu=0x1234.
  - Response: after reset, out_valid=0 and in_ready=1. One cycle after acc: out_valid=1, wb_data=0x1234, fwd_en=1, fwd_addr=5.
- MemToReg select:
  - Stimulus: in_ctrl=2'b11, mem=0xDEADBEEF, alu=0x10, rd=7.
  - Response: wb_data=fwd_data=0xDEADBEEF.
- x0 suppression:
  - Stimulus: in_ctrl=2'b01, rd=0.
  - Response: out_ctrl[0]=0, fwd_en=0, out_valid=1.
- Backpressure and skid:
  - Stimulus: out_ready=0; push A, then B.
  - Response: after B, in_ready=0 and out_* holds A.
  - Then out_ready=1: A, B emerge on consecutive cycles, in_ready returns to 1, no loss or duplication.
- Flush while FULL, with concurrent input:
  - Stimulus: flush=1 with in_valid=1.
  - Response: next cycle out_valid=0, out_ctrl=0, in_ready=1, and the input beat is absent.
- Reset mid-stream:
  - Stimulus: reset=1 in FULL with flush=0, out_ready=1.
  - Response: next cycle all outputs 0 and in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back control bit positions, default widths and the
// occupancy encoding used by the pipeline skid buffers.
package pipe_pkg;

  localparam int unsigned WB_REGWRITE_BIT = 0;
  localparam int unsigned WB_MEMTOREG_BIT = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered ready/valid. On flush, the top CLR_W payload bits of
// both entries are cleared so control fields cannot leak into a later cycle.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CLR_W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   st_q;
  logic [W-1:0] main_q, skid_q;
  logic         in_ready_q, out_valid_q;
  logic         acc, pop;

  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Any beat accepted this cycle is dropped; the data fields may keep stale values.
      st_q                   <= EMPTY;
      main_q[W-1 -: CLR_W]   <= '0;
      skid_q[W-1 -: CLR_W]   <= '0;
      in_ready_q             <= 1'b1;
      out_valid_q            <= 1'b0;
    end else begin
      case (st_q)
        EMPTY: begin
          if (acc) begin
            main_q      <= in_data;
            st_q        <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q     <= in_data;
            st_q       <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            st_q        <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q     <= skid_q;
            st_q       <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          st_q        <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary: skid-buffered handshake stage with x0 write suppression, write-back data
// select and a forwarding tap driven only from the head registers.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_en,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned PW = CTRL_W + 2 * DATA_W + ADDR_W;

  logic [CTRL_W-1:0] cap_ctrl;
  logic [PW-1:0]     in_pl, out_pl;

  always_comb begin
    cap_ctrl                  = in_ctrl;
    cap_ctrl[WB_REGWRITE_BIT] = in_ctrl[WB_REGWRITE_BIT] & (in_rd_addr != '0);
  end

  // Control sits in the MSBs so the buffer's flush clear hits exactly the ctrl field.
  assign in_pl = {cap_ctrl, in_mem_data, in_alu_data, in_rd_addr};

  pipe_skid_buf #(
    .W     (PW),
    .CLR_W (CTRL_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign {out_ctrl, out_mem_data, out_alu_data, out_rd_addr} = out_pl;

  assign wb_data  = out_ctrl[WB_MEMTOREG_BIT] ? out_mem_data : out_alu_data;
  assign fwd_en   = out_valid & out_ctrl[WB_REGWRITE_BIT];
  assign fwd_addr = out_rd_addr;
  assign fwd_data = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a directed vector table followed by randomized traffic, both
// shadowed by a queue-based model of the stage's occupancy and contents.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, fwd_en;
  logic [1:0]  in_ctrl, out_ctrl;
  logic [31:0] in_mem_data, in_alu_data, out_mem_data, out_alu_data, wb_data, fwd_data;
  logic [4:0]  in_rd_addr, out_rd_addr, fwd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_mem_data  (in_mem_data),
    .in_alu_data  (in_alu_data),
    .in_rd_addr   (in_rd_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_mem_data (out_mem_data),
    .out_alu_data (out_alu_data),
    .out_rd_addr  (out_rd_addr),
    .wb_data      (wb_data),
    .fwd_en       (fwd_en),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
  );

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [1:0]  ctrl;
    logic [31:0] mem, alu;
    logic [4:0]  rd;
    logic        e_ov, e_ir;
    logic [1:0]  e_ctrl;
    logic [31:0] e_wb;
    logic        e_fe;
    logic [4:0]  e_fa;
  } vec_t;

  // Model: the stage is a FIFO of depth two; the head is what out_* shows.
  ent_t q[$];
  bit   zero_all  = 1'b0;
  bit   ctrl_zero = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    ent_t        h;
    logic [31:0] wb;
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      h  = q[0];
      wb = h.ctrl[1] ? h.mem : h.alu;
      chk("m_ctrl", 32'(out_ctrl), 32'(h.ctrl));
      chk("m_mem", out_mem_data, h.mem);
      chk("m_alu", out_alu_data, h.alu);
      chk("m_rd", 32'(out_rd_addr), 32'(h.rd));
      chk("m_wb", wb_data, wb);
      chk("m_fwd_en", 32'(fwd_en), 32'(h.ctrl[0]));
      chk("m_fwd_addr", 32'(fwd_addr), 32'(h.rd));
      chk("m_fwd_data", fwd_data, wb);
    end else begin
      chk("m_fwd_en_idle", 32'(fwd_en), 32'd0);
      if (zero_all) begin
        chk("m_rst_mem", out_mem_data, 32'd0);
        chk("m_rst_alu", out_alu_data, 32'd0);
        chk("m_rst_rd", 32'(out_rd_addr), 32'd0);
        chk("m_rst_wb", wb_data, 32'd0);
      end
      if (zero_all || ctrl_zero) chk("m_idle_ctrl", 32'(out_ctrl), 32'd0);
    end
  endtask

  // One clock: decide acc/pop from the pre-edge view, update the model, check mid-cycle.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    acc    = in_valid && (q.size() < 2);
    pop    = (q.size() > 0) && out_ready;
    e.ctrl = in_ctrl;
    if (in_rd_addr == 5'd0) e.ctrl[0] = 1'b0;
    e.mem  = in_mem_data;
    e.alu  = in_alu_data;
    e.rd   = in_rd_addr;
    @(posedge clk);
    if (reset) begin
      q.delete();
      zero_all  = 1'b1;
      ctrl_zero = 1'b1;
    end else if (flush) begin
      q.delete();
      ctrl_zero = 1'b1;
    end else begin
      if (pop) q.delete(0);
      if (acc) begin
        q.push_back(e);
        zero_all  = 1'b0;
        ctrl_zero = 1'b0;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic vec_t mk(input logic rst, fl, iv, ordy, input logic [1:0] ctrl,
                              input logic [31:0] mem, alu, input logic [4:0] rd,
                              input logic e_ov, e_ir, input logic [1:0] e_ctrl,
                              input logic [31:0] e_wb, input logic e_fe, input logic [4:0] e_fa);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.ctrl = ctrl;
    v.mem = mem; v.alu = alu; v.rd = rd; v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_ctrl = e_ctrl; v.e_wb = e_wb; v.e_fe = e_fe; v.e_fa = e_fa;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // rst fl iv ordy ctrl mem alu rd | ov ir ctrl wb fe fa
    vt.push_back(mk(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h0, 0, 5'd0));
    vt.push_back(mk(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h0, 0, 5'd0));
    vt.push_back(mk(0, 0, 1, 1, 2'b01, 32'h0, 32'h1234, 5'd5, 1, 1, 2'b01, 32'h1234, 1, 5'd5));
    vt.push_back(mk(0, 0, 1, 1, 2'b11, 32'hDEADBEEF, 32'h10, 5'd7,
                    1, 1, 2'b11, 32'hDEADBEEF, 1, 5'd7));
    vt.push_back(mk(0, 0, 1, 1, 2'b01, 32'h0, 32'h55, 5'd0, 1, 1, 2'b00, 32'h55, 0, 5'd0));
    vt.push_back(mk(0, 0, 0, 1, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h55, 0, 5'd0));
    vt.push_back(mk(0, 0, 1, 0, 2'b01, 32'h0, 32'hAAAA, 5'd3, 1, 1, 2'b01, 32'hAAAA, 1, 5'd3));
    vt.push_back(mk(0, 0, 1, 0, 2'b11, 32'hBBBB, 32'h0, 5'd4, 1, 0, 2'b01, 32'hAAAA, 1, 5'd3));
    vt.push_back(mk(0, 0, 1, 0, 2'b01, 32'h0, 32'hCCCC, 5'd6, 1, 0, 2'b01, 32'hAAAA, 1, 5'd3));
    vt.push_back(mk(0, 0, 0, 1, 2'b00, 32'h0, 32'h0, 5'd0, 1, 1, 2'b11, 32'hBBBB, 1, 5'd4));
    vt.push_back(mk(0, 0, 0, 1, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b11, 32'hBBBB, 0, 5'd4));
    vt.push_back(mk(0, 0, 1, 0, 2'b01, 32'h0, 32'h99, 5'd9, 1, 1, 2'b01, 32'h99, 1, 5'd9));
    vt.push_back(mk(0, 0, 1, 0, 2'b01, 32'h0, 32'hA0, 5'd10, 1, 0, 2'b01, 32'h99, 1, 5'd9));
    vt.push_back(mk(0, 1, 1, 0, 2'b01, 32'h0, 32'hB0, 5'd11, 0, 1, 2'b00, 32'h99, 0, 5'd9));
    vt.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h99, 0, 5'd9));
    vt.push_back(mk(0, 0, 1, 1, 2'b01, 32'h0, 32'hC0, 5'd12, 1, 1, 2'b01, 32'hC0, 1, 5'd12));
    vt.push_back(mk(0, 0, 1, 0, 2'b01, 32'h0, 32'hD0, 5'd13, 1, 0, 2'b01, 32'hC0, 1, 5'd12));
    vt.push_back(mk(1, 0, 0, 1, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h0, 0, 5'd0));
    vt.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 1, 2'b00, 32'h0, 0, 5'd0));

    foreach (vt[i]) begin
      reset       = vt[i].rst;
      flush       = vt[i].fl;
      in_valid    = vt[i].iv;
      out_ready   = vt[i].ordy;
      in_ctrl     = vt[i].ctrl;
      in_mem_data = vt[i].mem;
      in_alu_data = vt[i].alu;
      in_rd_addr  = vt[i].rd;
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("v%0d_out_ctrl", i), 32'(out_ctrl), 32'(vt[i].e_ctrl));
      chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].e_wb);
      chk($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].e_wb);
      chk($sformatf("v%0d_fwd_en", i), 32'(fwd_en), 32'(vt[i].e_fe));
      chk($sformatf("v%0d_fwd_addr", i), 32'(fwd_addr), 32'(vt[i].e_fa));
    end

    // Full throughput: with out_ready held high the stage never fills.
    for (int i = 0; i < 20; i++) begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_ctrl = 2'(i); in_mem_data = $urandom; in_alu_data = $urandom; in_rd_addr = 5'(i + 1);
      step();
      chk("tput_in_ready", 32'(in_ready), 32'd1);
    end

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      in_ctrl     = 2'($urandom);
      in_mem_data = $urandom;
      in_alu_data = $urandom;
      in_rd_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
